// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
package data_mem_arbiter_pkg;

    localparam int RW_EN_W = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } arb_state_e;

    // One latched memory request as presented on the shared port.
    typedef struct packed {
        logic [RW_EN_W-1:0] en;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Drives the shared data-memory port: the latched request while an access
// owns the port, all zero otherwise.
module dmem_port_mux
    import data_mem_arbiter_pkg::*;
(
    input  logic               sel_i,
    input  mem_req_t           req_i,
    output logic [RW_EN_W-1:0] mem_en_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o
);

    // Select the latched request or park the port at zero.
    always_comb begin
        mem_en_o    = {RW_EN_W{1'b0}};
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = {DATA_W{1'b0}};
        if (sel_i) begin
            mem_en_o    = req_i.en;
            mem_addr_o  = req_i.addr;
            mem_wdata_o = req_i.wdata;
        end else begin
            mem_en_o    = {RW_EN_W{1'b0}};
            mem_addr_o  = {ADDR_W{1'b0}};
            mem_wdata_o = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a
// DMA/loader requester. Each access holds the port for ACCESS_CYCLES cycles;
// the CPU is stalled through CPU_BUSYWAIT and the DMA gets a one-cycle ACK.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [RW_EN_W-1:0] CPU_READ_WRITE_EN,
    input  logic [ADDR_W-1:0]  CPU_ADDRESS,
    input  logic [DATA_W-1:0]  CPU_WRITEDATA,
    output logic [DATA_W-1:0]  CPU_READDATA,
    output logic               CPU_BUSYWAIT,
    input  logic               DMA_REQ,
    input  logic [RW_EN_W-1:0] DMA_READ_WRITE_EN,
    input  logic [ADDR_W-1:0]  DMA_ADDRESS,
    input  logic [DATA_W-1:0]  DMA_WRITEDATA,
    output logic [DATA_W-1:0]  DMA_READDATA,
    output logic               DMA_ACK,
    output logic [RW_EN_W-1:0] MEM_READ_WRITE_EN,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [DATA_W-1:0]  MEM_WRITEDATA,
    input  logic [DATA_W-1:0]  MEM_READDATA
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    mem_req_t           req_q, req_d;
    logic               cpu_done_q, cpu_done_d;
    logic               dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  dma_rdata_q, dma_rdata_d;
    logic               cpu_req_s;
    logic               dma_req_s;

    // The done/ack masks keep a just-served requester from being re-granted
    // in its completion cycle.
    assign cpu_req_s = (CPU_READ_WRITE_EN != {RW_EN_W{1'b0}}) && !cpu_done_q;
    assign dma_req_s = DMA_REQ && !dma_ack_q;

    assign CPU_BUSYWAIT = RESET && cpu_req_s;
    assign CPU_READDATA = cpu_rdata_q;
    assign DMA_READDATA = dma_rdata_q;
    assign DMA_ACK      = dma_ack_q;

    // Arbitration, access sequencing and completion capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        req_d       = req_q;
        cpu_done_d  = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (dma_req_s && ((starve_q == STV_MAX) || !cpu_req_s)) begin
                    state_d  = DMA_ACC;
                    req_d    = '{en: DMA_READ_WRITE_EN, addr: DMA_ADDRESS, wdata: DMA_WRITEDATA};
                    starve_d = {STV_W{1'b0}};
                end else if (cpu_req_s) begin
                    state_d = CPU_ACC;
                    req_d   = '{en: CPU_READ_WRITE_EN, addr: CPU_ADDRESS, wdata: CPU_WRITEDATA};
                    if (DMA_REQ) begin
                        starve_d = (starve_q == STV_MAX) ? STV_MAX : starve_q + STV_W'(1);
                    end else begin
                        starve_d = {STV_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    if (state_q == CPU_ACC) begin
                        cpu_rdata_d = MEM_READDATA;
                        cpu_done_d  = 1'b1;
                    end else begin
                        dma_rdata_d = MEM_READDATA;
                        dma_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            starve_q    <= {STV_W{1'b0}};
            req_q       <= '0;
            cpu_done_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            dma_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            req_q       <= req_d;
            cpu_done_q  <= cpu_done_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    dmem_port_mux u_port_mux (
        .sel_i       (state_q != IDLE),
        .req_i       (req_q),
        .mem_en_o    (MEM_READ_WRITE_EN),
        .mem_addr_o  (MEM_ADDRESS),
        .mem_wdata_o (MEM_WRITEDATA)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_data_mem_arbiter;

    localparam int AC = 2;
    localparam int SL = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  CPU_READ_WRITE_EN;
    logic [31:0] CPU_ADDRESS, CPU_WRITEDATA, CPU_READDATA;
    logic        CPU_BUSYWAIT;
    logic        DMA_REQ;
    logic [3:0]  DMA_READ_WRITE_EN;
    logic [31:0] DMA_ADDRESS, DMA_WRITEDATA, DMA_READDATA;
    logic        DMA_ACK;
    logic [3:0]  MEM_READ_WRITE_EN;
    logic [31:0] MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_READ_WRITE_EN(CPU_READ_WRITE_EN), .CPU_ADDRESS(CPU_ADDRESS),
        .CPU_WRITEDATA(CPU_WRITEDATA), .CPU_READDATA(CPU_READDATA),
        .CPU_BUSYWAIT(CPU_BUSYWAIT),
        .DMA_REQ(DMA_REQ), .DMA_READ_WRITE_EN(DMA_READ_WRITE_EN),
        .DMA_ADDRESS(DMA_ADDRESS), .DMA_WRITEDATA(DMA_WRITEDATA),
        .DMA_READDATA(DMA_READDATA), .DMA_ACK(DMA_ACK),
        .MEM_READ_WRITE_EN(MEM_READ_WRITE_EN), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          who;     // 1 = CPU, 2 = DMA
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    bit          m_busy;
    txn_t        m_cur;
    int          m_cyc;       // index of the current clock cycle
    int          m_end;       // cycle whose closing edge completes m_cur
    int          m_starve;    // CPU grants in a row while DMA_REQ was up
    bit          m_cpu_done, m_ack;
    logic [31:0] m_cpu_rd, m_dma_rd;

    function automatic void model_reset();
        m_busy = 1'b0; m_cur = '{0, 4'h0, 32'h0, 32'h0};
        m_cyc = 0; m_end = 0; m_starve = 0;
        m_cpu_done = 1'b0; m_ack = 1'b0;
        m_cpu_rd = 32'h0; m_dma_rd = 32'h0;
    endfunction

    // Applies one rising edge using the inputs present before it.
    function automatic void model_edge();
        bit cpu_want = (CPU_READ_WRITE_EN != 4'h0) && !m_cpu_done;
        bit dma_want = DMA_REQ && !m_ack;
        bit nd = 1'b0;
        bit na = 1'b0;
        if (m_busy) begin
            if (m_cyc == m_end) begin
                if (m_cur.who == 1) begin m_cpu_rd = MEM_READDATA; nd = 1'b1; end
                else begin m_dma_rd = MEM_READDATA; na = 1'b1; end
                m_busy = 1'b0;
            end
        end else if (dma_want && (m_starve >= SL || !cpu_want)) begin
            m_busy = 1'b1;
            m_cur = '{2, DMA_READ_WRITE_EN, DMA_ADDRESS, DMA_WRITEDATA};
            m_end = m_cyc + AC;
            m_starve = 0;
        end else if (cpu_want) begin
            m_busy = 1'b1;
            m_cur = '{1, CPU_READ_WRITE_EN, CPU_ADDRESS, CPU_WRITEDATA};
            m_end = m_cyc + AC;
            m_starve = DMA_REQ ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        end
        m_cpu_done = nd;
        m_ack = na;
        m_cyc++;
    endfunction

    // Observations of the most recent cycle, for the directed sequences.
    logic        obs_busy, obs_ack;
    logic [3:0]  obs_en;
    logic [31:0] obs_addr, obs_wd, obs_cpu_rd, obs_dma_rd;

    // One clock cycle: compare all outputs with the model, then take the edge.
    task automatic cycle();
        if (!RESET) model_reset();
        #1;
        chk("busywait", 32'(CPU_BUSYWAIT), 32'(RESET && (CPU_READ_WRITE_EN != 4'h0) && !m_cpu_done));
        chk("mem_en",    32'(MEM_READ_WRITE_EN), m_busy ? 32'(m_cur.en) : 32'h0);
        chk("mem_addr",  MEM_ADDRESS,   m_busy ? m_cur.addr : 32'h0);
        chk("mem_wdata", MEM_WRITEDATA, m_busy ? m_cur.wd   : 32'h0);
        chk("cpu_rdata", CPU_READDATA, m_cpu_rd);
        chk("dma_rdata", DMA_READDATA, m_dma_rd);
        chk("dma_ack",   32'(DMA_ACK), 32'(m_ack));
        obs_busy = CPU_BUSYWAIT; obs_ack = DMA_ACK; obs_en = MEM_READ_WRITE_EN;
        obs_addr = MEM_ADDRESS; obs_wd = MEM_WRITEDATA;
        obs_cpu_rd = CPU_READDATA; obs_dma_rd = DMA_READDATA;
        @(posedge CLK);
        if (RESET) model_edge();
        #1;
    endtask

    // Keep the CPU request up until the done cycle, then withdraw it.
    task automatic finish_cpu(input string name);
        bit got = 1'b0;
        for (int t = 0; t < 8; t++) begin
            cycle();
            if (!obs_busy) begin got = 1'b1; break; end
        end
        chk(name, 32'(got), 32'h1);
        CPU_READ_WRITE_EN = 4'h0;
        cycle();
    endtask

    typedef struct {
        bit          is_dma;
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          exp_lat;    // CPU: busywait cycles; DMA: cycles from REQ to ACK
        int          exp_mem;    // cycles the port carries this address
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, memc, cpu_before, cpu_after;
        bit got, dma_seen;

        vecs[0] = '{1'b0, 4'b0001, 32'h10, 32'h0,        32'hDEADBEEF, AC + 1, AC, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 4'b1111, 32'h44, 32'h12345678, 32'h0BADF00D, AC + 1, AC, 32'h0BADF00D};
        vecs[2] = '{1'b1, 4'b0010, 32'h20, 32'h5A5A5A5A, 32'h11111111, AC + 1, AC, 32'h11111111};
        vecs[3] = '{1'b1, 4'b0100, 32'h80, 32'h0,        32'hCAFEF00D, AC + 1, AC, 32'hCAFEF00D};

        RESET = 1'b0;
        CPU_READ_WRITE_EN = 4'b0001; CPU_ADDRESS = 32'h10; CPU_WRITEDATA = 32'h0;
        DMA_REQ = 1'b0; DMA_READ_WRITE_EN = 4'h0; DMA_ADDRESS = 32'h0; DMA_WRITEDATA = 32'h0;
        MEM_READDATA = 32'hDEADBEEF;
        model_reset();
        @(posedge CLK); #1;

        // Reset: everything zero, busywait forced low despite a pending request.
        cycle();
        chk("rst_busy", 32'(obs_busy), 32'h0);
        chk("rst_mem_en", 32'(obs_en), 32'h0);
        RESET = 1'b1;
        cycle();
        chk("rel_busy", 32'(obs_busy), 32'h1);
        chk("rel_mem_en_idle", 32'(obs_en), 32'h0);
        cycle();
        chk("rel_mem_en_grant", 32'(obs_en), 32'h1);
        finish_cpu("rel_cpu_done");

        // Single transactions from idle.
        foreach (vecs[i]) begin
            MEM_READDATA = vecs[i].rd;
            if (vecs[i].is_dma) begin
                DMA_REQ = 1'b1; DMA_READ_WRITE_EN = vecs[i].en;
                DMA_ADDRESS = vecs[i].addr; DMA_WRITEDATA = vecs[i].wd;
            end else begin
                CPU_READ_WRITE_EN = vecs[i].en;
                CPU_ADDRESS = vecs[i].addr; CPU_WRITEDATA = vecs[i].wd;
            end
            lat = 0; memc = 0; got = 1'b0;
            for (int t = 0; t < 12; t++) begin
                cycle();
                if (obs_en != 4'h0 && obs_addr == vecs[i].addr && obs_wd == vecs[i].wd) memc++;
                if (vecs[i].is_dma) begin
                    if (obs_ack) begin
                        got = 1'b1; lat = t;
                        chk("vec_dma_rdata", obs_dma_rd, vecs[i].exp_rdata);
                        break;
                    end
                end else if (obs_busy) begin
                    lat++;
                end else begin
                    got = 1'b1;
                    chk("vec_cpu_rdata", obs_cpu_rd, vecs[i].exp_rdata);
                    break;
                end
            end
            chk("vec_done", 32'(got), 32'h1);
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_mem_cycles", memc, vecs[i].exp_mem);
            CPU_READ_WRITE_EN = 4'h0; DMA_REQ = 1'b0;
            cycle(); cycle();
        end

        // Reset in the first access cycle: port drops at once, no completion.
        CPU_READ_WRITE_EN = 4'b0001; CPU_ADDRESS = 32'h40; MEM_READDATA = 32'h77777777;
        cycle();
        RESET = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(MEM_READ_WRITE_EN), 32'h0);
        chk("midrst_busy", 32'(CPU_BUSYWAIT), 32'h0);
        cycle();
        RESET = 1'b1;
        cycle();
        chk("midrst_restart_busy", 32'(obs_busy), 32'h1);
        chk("midrst_restart_idle", 32'(obs_en), 32'h0);
        cycle();
        chk("midrst_regrant", 32'(obs_en), 32'h1);
        finish_cpu("midrst_cpu_done");

        // Flush: request withdrawn mid-access; access completes, done pulse masks a new request.
        CPU_READ_WRITE_EN = 4'b0011; CPU_ADDRESS = 32'h30; MEM_READDATA = 32'h33333333;
        cycle();
        cycle();
        CPU_READ_WRITE_EN = 4'h0;
        cycle();
        chk("flush_busy", 32'(obs_busy), 32'h0);
        chk("flush_still_on_port", 32'(obs_en), 32'h3);
        CPU_READ_WRITE_EN = 4'b0001;
        cycle();
        chk("flush_done_masks", 32'(obs_busy), 32'h0);
        chk("flush_port_idle", 32'(obs_en), 32'h0);
        chk("flush_rdata", obs_cpu_rd, 32'h33333333);
        finish_cpu("flush_next_done");

        // Contention: CPU wins the simultaneous request; DMA waits at most SL CPU accesses.
        CPU_READ_WRITE_EN = 4'b0001; CPU_ADDRESS = 32'h100; CPU_WRITEDATA = 32'h0;
        DMA_REQ = 1'b1; DMA_READ_WRITE_EN = 4'b0010; DMA_ADDRESS = 32'h200; DMA_WRITEDATA = 32'hABCD0123;
        cpu_before = 0; cpu_after = 0; dma_seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (t == 1) chk("cont_first_grant_cpu", obs_addr, 32'h100);
            if (!obs_busy) begin
                if (dma_seen) cpu_after++;
                else cpu_before++;
            end
            if (obs_ack) begin dma_seen = 1'b1; DMA_REQ = 1'b0; end
            if (dma_seen && cpu_after > 0) break;
        end
        chk("cont_dma_served", 32'(dma_seen), 32'h1);
        chk("cont_dma_bound", 32'(cpu_before <= SL), 32'h1);
        chk("cont_cpu_after", 32'(cpu_after > 0), 32'h1);
        CPU_READ_WRITE_EN = 4'h0; DMA_REQ = 1'b0;
        cycle(); cycle(); cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (!RESET) RESET = 1'b1;
            else if ($urandom_range(0, 149) == 0) RESET = 1'b0;
            if (DMA_REQ && obs_ack) DMA_REQ = 1'b0;
            else if (!DMA_REQ && $urandom_range(0, 3) == 0) begin
                DMA_REQ = 1'b1;
                DMA_READ_WRITE_EN = 4'($urandom_range(1, 15));
                DMA_ADDRESS = $urandom; DMA_WRITEDATA = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                CPU_READ_WRITE_EN = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                CPU_ADDRESS = $urandom; CPU_WRITEDATA = $urandom;
            end
            MEM_READDATA = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
